// File: rtl/isqrt_seq_param.sv
// rtl/isqrt_seq_param.sv - sequential digit-by-digit integer square root, BITS_PER_CYCLE root bits per clock
module isqrt_seq_param #(
  parameter int IN_W           = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [IN_W-1:0]     radicand_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [IN_W/2-1:0]   root_o,
  output logic [IN_W/2:0]     rem_o
);

  localparam int OUT_W  = IN_W / 2;
  localparam int N_ITER = OUT_W / BITS_PER_CYCLE;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [IN_W-1:0]    rad_q, rad_nxt;
  logic [OUT_W-1:0]   q_q, q_nxt;
  logic [OUT_W+1:0]   r_q, r_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               last_iter;

  assign accept    = start_i && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt_q == CNT_W'(N_ITER - 1));

  // One clock's worth of root digits, chained combinationally.
  always_comb begin
    r_nxt   = r_q;
    q_nxt   = q_q;
    rad_nxt = rad_q;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      r_nxt = {r_nxt[OUT_W-1:0], rad_nxt[IN_W-1 -: 2]};
      if (r_nxt >= {q_nxt, 2'b01}) begin
        r_nxt = r_nxt - {q_nxt, 2'b01};
        q_nxt = {q_nxt[OUT_W-2:0], 1'b1};
      end else begin
        q_nxt = {q_nxt[OUT_W-2:0], 1'b0};
      end
      rad_nxt = {rad_nxt[IN_W-3:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = CALC;
      CALC: begin
        busy_o = 1'b1;
        if (abort_i)        state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = start_i ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results load only on the final iteration, so they hold through the next computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      root_o <= '0;
      rem_o  <= '0;
    end else if (accept) begin
      rad_q <= radicand_i;
      q_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else if (state == CALC && !abort_i) begin
      rad_q <= rad_nxt;
      q_q   <= q_nxt;
      r_q   <= r_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_iter) begin
        root_o <= q_nxt;
        rem_o  <= r_nxt[OUT_W:0];
      end
    end
  end

endmodule

// File: tb/tb_isqrt_seq_param.sv
// tb/tb_isqrt_seq_param.sv - scoreboard bench for isqrt_seq_param in two configurations
module tb_isqrt_seq_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [15:0] rad_a = '0;
  logic        busy_a, done_a;
  logic [7:0]  root_a;
  logic [8:0]  rem_a;

  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [31:0] rad_b = '0;
  logic        busy_b, done_b;
  logic [15:0] root_b;
  logic [16:0] rem_b;

  isqrt_seq_param #(.IN_W(16), .BITS_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a), .radicand_i(rad_a),
    .busy_o(busy_a), .done_o(done_a), .root_o(root_a), .rem_o(rem_a)
  );

  isqrt_seq_param #(.IN_W(32), .BITS_PER_CYCLE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b), .radicand_i(rad_b),
    .busy_o(busy_b), .done_o(done_b), .root_o(root_b), .rem_o(rem_b)
  );

  typedef struct {
    longint root;
    longint rem;
    longint cyc;
  } exp_t;

  typedef struct {
    longint x;
    longint root;
    longint rem;
  } vec_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  exp_t   ea, eb;
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  bit     prev_a = 1'b0, prev_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint ref_root(input longint x);
    longint r;
    r = longint'($floor($sqrt(real'(x))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  always @(negedge clk) begin
    if (done_a) begin
      chk("done_width_a", longint'(prev_a), 0);
      if (q_a.size() == 0) chk("unexpected_done_a", 1, 0);
      else begin
        ea = q_a.pop_front();
        chk("root_a", longint'(root_a), ea.root);
        chk("rem_a", longint'(rem_a), ea.rem);
        chk("latency_a", cyc, ea.cyc);
      end
    end
    prev_a = done_a;
  end

  always @(negedge clk) begin
    if (done_b) begin
      chk("done_width_b", longint'(prev_b), 0);
      if (q_b.size() == 0) chk("unexpected_done_b", 1, 0);
      else begin
        eb = q_b.pop_front();
        chk("root_b", longint'(root_b), eb.root);
        chk("rem_b", longint'(rem_b), eb.rem);
        chk("latency_b", cyc, eb.cyc);
      end
    end
    prev_b = done_b;
  end

  // Both configurations resolve their root in 8 iterations.
  task automatic issue(input int sel, input longint x, input bit push, input bit hold,
                       input longint er, input longint erem);
    exp_t e;
    if (sel == 0) begin start_a = 1'b1; rad_a = x[15:0]; end
    else          begin start_b = 1'b1; rad_b = x[31:0]; end
    @(posedge clk);
    #1;
    if (push) begin
      e.root = er;
      e.rem  = erem;
      e.cyc  = cyc + 8;
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
    end
    if (!hold) begin
      if (sel == 0) start_a = 1'b0;
      else          start_b = 1'b0;
    end
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((sel == 0) ? done_a : done_b) && n < 40);
    if (!((sel == 0) ? done_a : done_b)) chk("done_timeout", 0, 1);
  endtask

  vec_t vec_a[6] = '{'{65535, 255, 510}, '{0, 0, 0}, '{1, 1, 0},
                     '{15, 3, 6}, '{16, 4, 0}, '{200, 14, 4}};
  vec_t vec_b[5] = '{'{64'd4294967295, 65535, 131070}, '{0, 0, 0},
                     '{1000000, 1000, 0}, '{999999, 999, 1998}, '{3, 1, 2}};

  initial begin
    #1;
    chk("reset_busy_a", longint'(busy_a), 0);
    chk("reset_done_a", longint'(done_a), 0);
    chk("reset_root_a", longint'(root_a), 0);
    chk("reset_rem_a", longint'(rem_a), 0);
    chk("reset_root_b", longint'(root_b), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, vec_a[0].x, 1, 0, vec_a[0].root, vec_a[0].rem);
    chk("busy_in_calc_a", longint'(busy_a), 1);
    wait_done(0);
    for (int i = 1; i < 6; i++) begin
      issue(0, vec_a[i].x, 1, 0, vec_a[i].root, vec_a[i].rem);
      wait_done(0);
    end

    // Back-to-back with start held; radicand changes mid-flight must not matter.
    issue(0, 144, 1, 1, 12, 0);
    rad_a = 16'd143;
    wait_done(0);
    issue(0, 143, 1, 0, 11, 22);
    wait_done(0);

    issue(0, 10000, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 abort_a = 1'b1;
    @(posedge clk);
    #1 abort_a = 1'b0;
    chk("abort_busy_a", longint'(busy_a), 0);
    chk("abort_root_kept", longint'(root_a), 11);
    chk("abort_rem_kept", longint'(rem_a), 22);
    repeat (12) @(negedge clk);
    issue(0, 10000, 1, 0, 100, 0);
    wait_done(0);

    @(negedge clk);
    issue(0, 65535, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_root_a", longint'(root_a), 0);
    chk("midreset_rem_a", longint'(rem_a), 0);
    chk("midreset_busy_a", longint'(busy_a), 0);
    chk("midreset_done_a", longint'(done_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      longint x, r;
      x = longint'($urandom_range(0, 65535));
      r = ref_root(x);
      issue(0, x, 1, 0, r, x - r * r);
      wait_done(0);
    end

    for (int i = 0; i < 5; i++) begin
      issue(1, vec_b[i].x, 1, 0, vec_b[i].root, vec_b[i].rem);
      wait_done(1);
    end
    for (int i = 0; i < 200; i++) begin
      longint x, r;
      x = longint'($urandom);
      r = ref_root(x);
      issue(1, x, 1, 0, r, x - r * r);
      wait_done(1);
    end

    repeat (5) @(negedge clk);
    chk("pending_a", longint'(q_a.size()), 0);
    chk("pending_b", longint'(q_b.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
